turn_scheduler: RTL
===================

Name: turn_scheduler

Overview:
Sequences the four player lanes of the game datapath: grants exactly one player the turn at a time, times each turn with a prescaled tick, and advances round-robin while skipping eliminated players. Sits between the top-level game block and the per-player game_logic lanes. It drives the lane enable one-hot and the output-mux select, and declares the winner when one player remains.

Parameters:
TICK_DIV, 10000, clk cycles per turn tick (1 MHz clk -> 100 Hz tick)
TURN_TICKS, 200, ticks per turn before timeout (2 s at 100 Hz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a game from IDLE, ignored elsewhere
alive  input  4  per-player still-in-game mask, bit i = player i; sampled every cycle
done  input  4  per-player early end-of-turn request; only bit[cur_player] is honoured
cur_player  output  2  index of player holding the turn
grant  output  4  one-hot lane enable = (1<<cur_player) in TURN, else 0
turn_start  output  1  one-cycle pulse, first TURN cycle of each turn
turn_end  output  1  one-cycle pulse, cycle the turn is terminated
ticks_left  output  8  remaining ticks in current turn
game_over  output  1  high in OVER
winner  output  2  surviving player index, valid when winner_valid
winner_valid  output  1  high in OVER iff exactly one player survived

Behaviour:
- Reset (async, immediate): state IDLE; cur_player=0, grant=0, turn_start=0, turn_end=0, ticks_left=0, game_over=0, winner=0, winner_valid=0; prescaler=0.
- States: IDLE, SELECT, TURN, ADVANCE, OVER.
- IDLE: wait for start; on start -> SELECT with search base = player 3 (so the search begins at player 0).
- SELECT (1 cycle): popcount(alive) == 0 -> OVER, winner_valid=0. popcount == 1 -> OVER, winner = that index, winner_valid=1. Otherwise cur_player = first alive index after the base, searching (base+1)..(base+4) mod 4; ticks_left=TURN_TICKS; prescaler=0 -> TURN.
- TURN: grant one-hot; turn_start pulses on entry cycle. Prescaler counts 0..TICK_DIV-1. On wrap, ticks_left decrements by 1 and saturates at 0.
- Turn terminates on the first cycle that any of these holds:
  - ticks_left==0;
  - done[cur_player]==1;
  - alive[cur_player]==0 (player eliminated mid-turn).
  On termination: turn_end=1 that cycle, grant drops next cycle, -> ADVANCE. Simultaneous conditions give a single turn_end.
- ADVANCE (1 cycle): search base = cur_player -> SELECT. Latency from terminating cycle to next turn_start is 3 cycles.
- OVER: game_over=1; winner held; grant=0. start -> SELECT with base 3 and clears game_over/winner_valid on that cycle.
- done bits of non-current players are ignored. start outside IDLE/OVER is ignored.
- Mask changes during SELECT use the value sampled that cycle.
- Wrap-around: player 3 -> player 0. A sole alive player with others dropping out is resolved in SELECT, never given a further turn.
- Reset mid-turn drops grant and all pulses immediately, asynchronously.

Optional Feature:
PAUSE_FREEZE_EN: adds input pause (1 bit).
- Defined: while pause=1 in TURN, the prescaler and ticks_left hold; done and timeout are ignored; grant stays asserted. alive[cur_player]==0 still terminates the turn. Other states are unaffected.
- Undefined: no pause port; timing always runs.

Test Plan:
- Timeout: TICK_DIV=4, TURN_TICKS=3, alive=1111, start -> turn_start with cur_player=0; turn_end 12 cycles after turn_start; next turn_start for player 1, 3 cycles later.
- Early done: alive=1111, done[1] pulsed in player 1's turn -> immediate turn_end, then player 2. done[3] pulsed during player 1's turn -> ignored.
- Skip: alive=1011, sequence 0,1,3,0,...
  - clear alive[1] mid-turn of player 1 -> turn_end the same cycle, next player 3.
- Winner: alive drops to 0100 -> next SELECT enters OVER, winner=2, winner_valid=1, grant=0000.
  - alive=0000 at start -> OVER, winner_valid=0.
- Reset: assert rst mid-TURN -> all outputs 0 in the same cycle, state IDLE. start after release -> player 0 turn.
- PAUSE_FREEZE_EN: pause=1 for 50 cycles mid-turn -> ticks_left constant; turn_end delayed exactly 50 cycles.

Source files
------------

// File: rtl/turn_scheduler.sv
// Round-robin turn sequencer for four player lanes with tick-timed turns.
// Optional PAUSE_FREEZE_EN adds a pause input that freezes turn timing.
module turn_scheduler #(
    parameter int TICK_DIV   = 10000,
    parameter int TURN_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] alive,
    input  logic [3:0] done,
`ifdef PAUSE_FREEZE_EN
    input  logic       pause,
`endif
    output logic [1:0] cur_player,
    output logic [3:0] grant,
    output logic       turn_start,
    output logic       turn_end,
    output logic [7:0] ticks_left,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       winner_valid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_TURN    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [2:0]    state;
    logic [1:0]    base;
    logic [PW-1:0] prescaler;
    logic [2:0]    pop;
    logic [1:0]    next_idx;
    logic [1:0]    idx;
    logic          freeze;
    logic          in_turn;
    logic          term;
    logic          tick_wrap;

`ifdef PAUSE_FREEZE_EN
    assign freeze = pause;
`else
    assign freeze = 1'b0;
`endif

    assign pop       = 3'($countones(alive));
    assign in_turn   = (state == S_TURN);
    assign tick_wrap = (prescaler == PW'(TICK_DIV - 1));

    // Losing the player ends the turn even while timing is frozen.
    assign term = in_turn &&
                  (!alive[cur_player] ||
                   (!freeze && ((ticks_left == 8'd0) || done[cur_player])));

    assign grant     = in_turn ? (4'b0001 << cur_player) : 4'b0000;
    assign turn_end  = term;
    assign game_over = (state == S_OVER);

    // Scan descending so the nearest alive player after base wins.
    always_comb begin
        next_idx = base;
        idx      = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (alive[idx]) next_idx = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            base         <= 2'd3;
            prescaler    <= '0;
            cur_player   <= 2'd0;
            ticks_left   <= 8'd0;
            turn_start   <= 1'b0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
        end else begin
            turn_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base  <= 2'd3;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pop <= 3'd1) begin
                        winner_valid <= (pop == 3'd1);
                        if (pop == 3'd1) winner <= next_idx;
                        state <= S_OVER;
                    end else begin
                        cur_player <= next_idx;
                        ticks_left <= 8'(TURN_TICKS);
                        prescaler  <= '0;
                        turn_start <= 1'b1;
                        state      <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (term) begin
                        state <= S_ADVANCE;
                    end else if (!freeze) begin
                        if (tick_wrap) begin
                            prescaler <= '0;
                            if (ticks_left != 8'd0)
                                ticks_left <= ticks_left - 8'd1;
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    base  <= cur_player;
                    state <= S_SELECT;
                end
                S_OVER: begin
                    if (start) begin
                        winner_valid <= 1'b0;
                        base         <= 2'd3;
                        state        <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
